stump_mem_responder: RTL

//  Memory-side responder for the Stump datapath's memory port, the slave end of the fetch/ld/st requests.
//  - Accepts read requests (mem_ren) and write requests (mem_wen); fetch and ld are reads, st is a write.
//  - Inserts a programmable number of wait states, then completes the access with a one-cycle mem_ready pulse.
//  - Sits between the Stump core and an internal word-addressed RAM. The RAM is 16-bit and has 2**ADDR_W words.

---
 rtl/stump_mem_pkg.sv | 22 ++
 rtl/stump_mem_responder_if.sv | 23 ++
 rtl/stump_mem_array.sv | 25 ++
 rtl/stump_mem_responder.sv | 111 +++++++++++
 4 files changed

// File: rtl/stump_mem_pkg.sv
// Shared types for the Stump memory responder: FSM states, access op, data width.
package stump_mem_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // True when any address bit above the RAM index field is set
    function automatic logic addr_oob(input logic [15:0] a, input int aw);
        return (a >> aw) != 16'd0;
    endfunction

endpackage

// File: rtl/stump_mem_responder_if.sv
// Stump core memory port: request/address/data from the core, ready/err/data back.
interface stump_mem_responder_if;
    import stump_mem_pkg::*;

    logic              mem_ren;
    logic              mem_wen;
    logic [15:0]       address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              mem_ready;
    logic              mem_err;

    modport master (
        output mem_ren, mem_wen, address, data_in,
        input  data_out, mem_ready, mem_err
    );

    modport slave (
        input  mem_ren, mem_wen, address, data_in,
        output data_out, mem_ready, mem_err
    );

endinterface

// File: rtl/stump_mem_array.sv
// Single-port 2**ADDR_W x 16 RAM: synchronous write, registered read.
module stump_mem_array
    import stump_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/stump_mem_responder.sv
// Stump memory-port responder with WAIT_CYCLES wait states in front of a local RAM.
// Optional STUMP_MEM_BOUNDS_EN flags and blocks accesses beyond the RAM depth.
module stump_mem_responder
    import stump_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    stump_mem_responder_if.slave  bus
);

`ifdef STUMP_MEM_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [3:0] WLOAD =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    op_t               r_op;
    logic [3:0]        r_cnt;
    logic [15:0]       r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_ready;
    logic              r_err;
    logic              r_rd_zero;

    logic              w_idle;
    logic              w_req;
    logic [15:0]       w_addr;
    op_t               w_op;
    logic              w_oob;
    logic              w_go_resp;
    logic              w_re;
    logic              w_we;
    logic [DATA_W-1:0] w_q;

    // In IDLE the live bus is used so a zero-wait access can read immediately
    assign w_idle    = (r_state == IDLE);
    assign w_req     = bus.mem_ren | bus.mem_wen;
    assign w_addr    = w_idle ? bus.address : r_addr;
    assign w_op      = w_idle ? (bus.mem_wen ? OP_WRITE : OP_READ) : r_op;
    assign w_oob     = BOUNDS_EN && addr_oob(w_addr, ADDR_W);
    assign w_go_resp = (w_idle && w_req && (WAIT_CYCLES == 0))
                     || ((r_state == WAIT) && (r_cnt == 4'd0));
    assign w_re      = w_go_resp && (w_op == OP_READ) && !w_oob;
    assign w_we      = (r_state == RESP) && (r_op == OP_WRITE) && !w_oob;

    stump_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_addr[ADDR_W-1:0]),
        .i_wdata (r_data),
        .o_rdata (w_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= OP_READ;
            r_cnt     <= 4'd0;
            r_addr    <= 16'd0;
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr <= bus.address;
                        r_data <= bus.data_in;
                        r_op   <= w_op;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= WLOAD;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) r_state <= RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            // Outputs are registered alongside the transition into RESP
            if (w_go_resp) begin
                r_ready <= 1'b1;
                r_err   <= w_oob;
                if (w_op == OP_READ) r_rd_zero <= w_oob;
            end
        end
    end

    assign bus.data_out  = r_rd_zero ? '0 : w_q;
    assign bus.mem_ready = r_ready;
    assign bus.mem_err   = r_err;

endmodule
